// File: rtl/speed_ctrl_pkg.sv
// speed_ctrl_pkg: shared types, widths and duty stepping rule for the speed-control loop
package speed_ctrl_pkg;
   typedef enum logic [1:0] {IDLE, LOAD, COMPARE, UPDATE} state_t;
   localparam int CH_W = 3;
   localparam int DUTY_W = 8;
   function automatic logic [DUTY_W-1:0] step_duty(
      input logic [DUTY_W-1:0] duty,
      input logic [DUTY_W-1:0] set,
      input logic              lt,
      input logic              gt,
      input logic              eq,
      input logic [DUTY_W-1:0] step,
      input logic [DUTY_W-1:0] max_duty
   );
      logic [DUTY_W:0] up, dn;
      up = {1'b0, duty} + {1'b0, step};
      dn = {1'b0, duty} - {1'b0, step};
      if (set == '0) return '0;
      if (eq) return duty;
      if (lt) return (up > {1'b0, max_duty}) ? max_duty : up[DUTY_W-1:0];
      if (gt) return dn[DUTY_W] ? '0 : dn[DUTY_W-1:0];
      return duty;
   endfunction
endpackage

// File: rtl/speed_loop_seq_if.sv
// speed_loop_seq_if: setpoint/measured in, duty and update strobes out
interface speed_loop_seq_if #(parameter int NUM_CH = 2);
   import speed_ctrl_pkg::*;
   logic                     en;
   logic [DUTY_W*NUM_CH-1:0] setpoint;
   logic [DUTY_W*NUM_CH-1:0] measured;
   logic [DUTY_W*NUM_CH-1:0] duty;
   logic                     busy;
   logic                     upd_valid;
   logic [CH_W-1:0]          upd_ch;
   modport master (output en, setpoint, measured, input duty, busy, upd_valid, upd_ch);
   modport slave (input en, setpoint, measured, output duty, busy, upd_valid, upd_ch);
endinterface

// File: rtl/speed_loop_seq_cmp.sv
// speed_loop_seq_cmp: 8-bit magnitude comparator with sticky result flags
module speed_loop_seq_cmp
   import speed_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic [DUTY_W-1:0] in1,
   input  logic [DUTY_W-1:0] in2,
   output logic              less_than,
   output logic              greater_than,
   output logic              equal
);
   // flags accumulate until cleared, so the user must reset before each new operand pair
   always_ff @(posedge clk) begin
      if (reset) begin
         less_than <= 1'b0;
         greater_than <= 1'b0;
         equal <= 1'b0;
      end else if (en) begin
         less_than <= less_than | (in1 < in2);
         greater_than <= greater_than | (in1 > in2);
         equal <= equal | (in1 == in2);
      end
   end
endmodule

// File: rtl/speed_loop_seq.sv
// speed_loop_seq: once per period, sweeps channels through one shared comparator and steps duty
module speed_loop_seq
   import speed_ctrl_pkg::*;
#(
   parameter int NUM_CH   = 2,
   parameter int PERIOD   = 1000,
   parameter int STEP     = 1,
   parameter int MAX_DUTY = 255
) (
   input  logic clk,
   input  logic reset,
   speed_loop_seq_if.slave bus
);
   localparam int CNT_W = $clog2(PERIOD);
   state_t                   state, state_n;
   logic [CH_W-1:0]          ch, ch_n;
   logic [CNT_W-1:0]         cnt;
   logic [DUTY_W-1:0]        op_meas, op_set, cur_duty, new_duty;
   logic [DUTY_W*NUM_CH-1:0] duty_q;
   logic                     tick, last, wr, cmp_reset, lt, gt, eq;
   assign tick = bus.en && cnt == CNT_W'(PERIOD - 1);
   assign last = ch == CH_W'(NUM_CH - 1);
   assign wr = bus.en && state == UPDATE;
   assign cmp_reset = reset || state == LOAD;
   assign cur_duty = duty_q[ch*DUTY_W +: DUTY_W];
   assign new_duty = step_duty(cur_duty, op_set, lt, gt, eq, DUTY_W'(STEP), DUTY_W'(MAX_DUTY));
   assign bus.duty = duty_q;
   assign bus.busy = state != IDLE;
   assign bus.upd_valid = wr;
   assign bus.upd_ch = wr ? ch : '0;
   speed_loop_seq_cmp u_cmp (
      .clk(clk),
      .reset(cmp_reset),
      .en(state == COMPARE),
      .in1(op_meas),
      .in2(op_set),
      .less_than(lt),
      .greater_than(gt),
      .equal(eq)
   );
   // sequence LOAD/COMPARE/UPDATE per channel; dropping en aborts the sweep immediately
   always_comb begin
      state_n = state;
      ch_n = ch;
      case (state)
         IDLE: begin
            state_n = tick ? LOAD : IDLE;
            ch_n = tick ? '0 : ch;
         end
         LOAD: state_n = COMPARE;
         COMPARE: state_n = UPDATE;
         UPDATE: begin
            state_n = last ? IDLE : LOAD;
            ch_n = last ? ch : ch + 1'b1;
         end
         default: state_n = IDLE;
      endcase
      if (!bus.en) state_n = IDLE;
   end
   // control registers: FSM state, channel index and the period counter
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         ch <= '0;
         cnt <= '0;
      end else begin
         state <= state_n;
         ch <= ch_n;
         cnt <= (!bus.en || tick) ? '0 : cnt + 1'b1;
      end
   end
   // operands frozen in LOAD so input changes mid-compare are ignored; duty written only in UPDATE
   always_ff @(posedge clk) begin
      if (reset) begin
         op_meas <= '0;
         op_set <= '0;
         duty_q <= '0;
      end else begin
         if (state == LOAD) begin
            op_meas <= bus.measured[ch*DUTY_W +: DUTY_W];
            op_set <= bus.setpoint[ch*DUTY_W +: DUTY_W];
         end
         if (wr) duty_q[ch*DUTY_W +: DUTY_W] <= new_duty;
      end
   end
endmodule
